seq_divider: RTL and testbench

//  Sequential restoring unsigned divider: the division counterpart of the shift-add

---
 rtl/seq_divider.sv | 157 +++++++++++++++
 tb/tb_seq_divider.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider
//   Sequential restoring unsigned divider. One quotient bit is resolved per
//   clock in CALC; an up-counter sequences the DATA_SIZE iterations. The
//   host handshake is start (sampled in IDLE only) -> busy -> done pulse.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; results and div_by_zero held
//   CALC   | one shift/trial-subtract per cycle, DATA_SIZE cycles
//   FINISH | publish quotient/remainder, pulse done, return to IDLE
//
// Ports
//   clk_i        clock, all logic on posedge
//   rst_i        synchronous active-high reset, priority over start
//   start        request a division (ignored unless IDLE)
//   dividend     unsigned dividend, captured with accepted start
//   divisor      unsigned divisor, captured with accepted start
//   quotient     registered quotient (all ones on divide by zero)
//   remainder    registered remainder (dividend on divide by zero)
//   busy         high while the iterations run
//   done         one-cycle pulse when results update
//   div_by_zero  set with done for a zero divisor, held with the results
module seq_divider #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] dividend,
  input  logic [DATA_SIZE-1:0] divisor,
  output logic [DATA_SIZE-1:0] quotient,
  output logic [DATA_SIZE-1:0] remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero
);

  localparam int CW = (DATA_SIZE > 2) ? $clog2(DATA_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE:0]   a_q, a_d;
  logic [DATA_SIZE-1:0] q_q, q_d;
  logic [DATA_SIZE-1:0] m_q, m_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATA_SIZE-1:0] quotient_q, quotient_d;
  logic [DATA_SIZE-1:0] remainder_q, remainder_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic [2*DATA_SIZE:0] aq_sh;
  logic [DATA_SIZE:0]   a_sh;
  logic [DATA_SIZE+1:0] trial;

  // Shift {A,Q} left; the extra sign bit of trial tells whether A_shifted < M.
  assign aq_sh = {a_q, q_q} << 1;
  assign a_sh  = aq_sh[2*DATA_SIZE:DATA_SIZE];
  assign trial = {1'b0, a_sh} - {2'b00, m_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = divisor;
          count_d = '0;
          if (divisor != '0) begin
            a_d     = '0;
            q_d     = dividend;
            busy_d  = 1'b1;
            dbz_d   = 1'b0;
            state_d = CALC;
          end else begin
            // Preload the divide-by-zero result so FINISH publishes it unchanged.
            a_d     = {1'b0, dividend};
            q_d     = '1;
            state_d = FINISH;
          end
        end
      end
      CALC: begin
        if (!trial[DATA_SIZE+1]) begin
          a_d = trial[DATA_SIZE:0];
          q_d = {aq_sh[DATA_SIZE-1:1], 1'b1};
        end else begin
          a_d = a_sh;
          q_d = aq_sh[DATA_SIZE-1:0];
        end
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          count_d = '0;
          busy_d  = 1'b0;
          state_d = FINISH;
        end
      end
      FINISH: begin
        quotient_d  = q_q;
        remainder_d = a_q[DATA_SIZE-1:0];
        dbz_d       = (m_q == '0);
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int N = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start;
  logic [N-1:0] dividend, divisor;
  logic [N-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.DATA_SIZE(N)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Presents a one-cycle start, then waits (bounded)
  // for done. Returns at the negedge where done is first seen high.
  task automatic run(input logic [N-1:0] dd, input logic [N-1:0] dv,
                     output int lat, output int busy_cyc);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(negedge clk_i);
    start    = 1'b0;
    lat      = 0;
    busy_cyc = busy ? 1 : 0;
    while (!done && lat < 30) begin
      @(negedge clk_i);
      lat++;
      if (busy) busy_cyc++;
    end
  endtask

  int lat, bc, ndone;
  logic [N-1:0] rd, rv;

  initial begin
    rst_i = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk_i);
    check("rst_quot", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // 100/7
    run(8'd100, 8'd7, lat, bc);
    check("t1_lat", lat, 9);
    check("t1_busy_cycles", bc, 8);
    check("t1_quot", quotient, 14);
    check("t1_rem", remainder, 2);
    check("t1_dbz", div_by_zero, 0);
    @(negedge clk_i);
    check("t1_done_one_cycle", done, 0);

    // directed vectors, back-to-back starts (next start in the cycle after done)
    run(8'd255, 8'd1, lat, bc);
    check("t2a_quot", quotient, 255); check("t2a_rem", remainder, 0);
    run(8'd5, 8'd9, lat, bc);
    check("t2b_quot", quotient, 0);   check("t2b_rem", remainder, 5);
    check("t2b_lat", lat, 9);
    run(8'd0, 8'd3, lat, bc);
    check("t2c_quot", quotient, 0);   check("t2c_rem", remainder, 0);
    run(8'd255, 8'd255, lat, bc);
    check("t2d_quot", quotient, 1);   check("t2d_rem", remainder, 0);

    // divide by zero, then a normal division clears the flag
    run(8'd200, 8'd0, lat, bc);
    check("t3_lat", lat, 1);
    check("t3_busy_cycles", bc, 0);
    check("t3_quot", quotient, 255);
    check("t3_rem", remainder, 200);
    check("t3_dbz", div_by_zero, 1);
    @(negedge clk_i);
    check("t3_dbz_held", div_by_zero, 1);
    check("t3_done_low", done, 0);
    run(8'd9, 8'd4, lat, bc);
    check("t3b_quot", quotient, 2);
    check("t3b_rem", remainder, 1);
    check("t3b_dbz", div_by_zero, 0);
    @(negedge clk_i);

    // start mid-CALC is ignored, inputs changing mid-op have no effect
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk_i);
    start = 1'b0;
    repeat (3) @(negedge clk_i);
    start = 1'b1; dividend = 8'd99; divisor = 8'd2;
    @(negedge clk_i);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      if (done) begin
        ndone++;
        check("t4_quot", quotient, 10);
        check("t4_rem", remainder, 0);
      end
    end
    check("t4_done_count", ndone, 1);

    // reset on the 4th CALC cycle aborts
    start = 1'b1; dividend = 8'd77; divisor = 8'd3;
    @(negedge clk_i);
    start = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("t5_quot", quotient, 0);
    check("t5_rem", remainder, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (done) ndone++;
    end
    check("t5_no_done", ndone, 0);
    run(8'd77, 8'd3, lat, bc);
    check("t5b_quot", quotient, 25);
    check("t5b_rem", remainder, 2);

    // random pairs, back-to-back
    for (int i = 0; i < 1000; i++) begin
      rd = N'($urandom_range(0, 255));
      rv = N'($urandom_range(1, 255));
      run(rd, rv, lat, bc);
      check("rnd_quot", quotient, rd / rv);
      check("rnd_rem", remainder, rd % rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
